// File: rtl/hazard_if.sv
// Hazard controller bundle: register specifiers and write/load/memory status
// from the pipeline stages, plus forwarding selects, stall/flush pins, fault
// flag and performance counters returned by the controller.
interface hazard_if #(
  parameter int CW = 16
);
  logic [4:0]    Rs1D, Rs2D;
  logic [4:0]    Rs1E, Rs2E, RdE;
  logic [4:0]    RdM, RdW;
  logic          RegWriteM, RegWriteW;
  logic          ResultSrcE0;
  logic          PCSrcE;
  logic          MemReqM, MemReadyM;
  logic [1:0]    ForwardAE, ForwardBE;
  logic          StallF, StallD, StallE, StallM;
  logic          FlushD, FlushE, FlushW;
  logic          MemFault;
  logic [CW-1:0] StallCount, FlushCount;

  // pipeline / control-unit side
  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MemReqM, MemReadyM,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
    input  FlushD, FlushE, FlushW, MemFault, StallCount, FlushCount
  );

  // hazard controller side
  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MemReqM, MemReadyM,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
    output FlushD, FlushE, FlushW, MemFault, StallCount, FlushCount
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage RV32I core: E-stage forwarding,
// load-use stall, branch/jump flush, data-memory freeze with timeout fault,
// and saturating stall/flush performance counters.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_RUN   | normal operation, no memory wait in progress
// ST_WAIT  | data memory not ready; wait_cnt_q counts consecutive waits
// ST_FAULT | memory timed out; pipeline frozen until reset
module hazard_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CW      = 16
) (
  input  logic    clk,
  input  logic    rst,
  hazard_if.slave hz
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_FAULT = 2'd2;

  localparam int             WCW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);
  localparam logic [CW-1:0]  CNT_MAX   = '1;

  logic [1:0]     state_q, state_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic [CW-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CW-1:0]  flush_cnt_q, flush_cnt_d;

  logic [1:0] fwd_a, fwd_b;
  logic       lw_stall, mem_wait;
  logic       stall_f, stall_d, stall_e, stall_m;
  logic       flush_d, flush_e, flush_w;
  logic       any_stall;

  // Forwarding selects; M-stage result beats W-stage result, x0 never forwards
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (rst) begin
      if (hz.RegWriteM && (hz.RdM != 5'd0) && (hz.RdM == hz.Rs1E))
        fwd_a = 2'b10;
      else if (hz.RegWriteW && (hz.RdW != 5'd0) && (hz.RdW == hz.Rs1E))
        fwd_a = 2'b01;
      if (hz.RegWriteM && (hz.RdM != 5'd0) && (hz.RdM == hz.Rs2E))
        fwd_b = 2'b10;
      else if (hz.RegWriteW && (hz.RdW != 5'd0) && (hz.RdW == hz.Rs2E))
        fwd_b = 2'b01;
    end
  end

  assign lw_stall = hz.ResultSrcE0 && (hz.RdE != 5'd0) &&
                    ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
  assign mem_wait = hz.MemReqM && !hz.MemReadyM;

  // Stall/flush priority: fault/memory freeze, then redirect flush, then load-use
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_w = 1'b0;
    if (rst) begin
      if ((state_q == ST_FAULT) || mem_wait) begin
        // whole pipeline held; W is bubbled so the stalled load retires once
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        stall_m = 1'b1;
        flush_w = 1'b1;
      end else if (hz.PCSrcE) begin
        // redirect kills the wrong-path instructions, including a load-use victim
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (lw_stall) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
    end
  end

  assign any_stall = stall_f | stall_d | stall_e | stall_m;

  // Memory-wait timeout FSM; a ready in the last allowed cycle still returns to RUN
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (mem_wait) begin
          state_d    = ST_WAIT;
          wait_cnt_d = WCW'(1);
        end
      end
      ST_WAIT: begin
        if (hz.MemReadyM) begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d    = ST_FAULT;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + WCW'(1);
        end
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Saturating performance counters
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (any_stall && (stall_cnt_q != CNT_MAX))
      stall_cnt_d = stall_cnt_q + CW'(1);
    if (flush_d && (flush_cnt_q != CNT_MAX))
      flush_cnt_d = flush_cnt_q + CW'(1);
  end

  // State and counter registers; reset wins over any increment at the same edge
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.ForwardAE  = fwd_a;
  assign hz.ForwardBE  = fwd_b;
  assign hz.StallF     = stall_f;
  assign hz.StallD     = stall_d;
  assign hz.StallE     = stall_e;
  assign hz.StallM     = stall_m;
  assign hz.FlushD     = flush_d;
  assign hz.FlushE     = flush_e;
  assign hz.FlushW     = flush_w;
  assign hz.MemFault   = (state_q == ST_FAULT);
  assign hz.StallCount = stall_cnt_q;
  assign hz.FlushCount = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: table vectors, hand-written multi-cycle
// sequences and random stimulus against a rule-level reference model.
module tb_hazard_ctrl;

  localparam int TIMEOUT = 4;
  localparam int CW      = 4;
  localparam int SMAX    = (1 << CW) - 1;

  typedef struct packed {
    logic       rst_n;
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic       regwm, regww, lde, pcsrc, memreq, memrdy;
  } inp_t;

  // stl = {F,D,E,M}, fls = {D,E,W}
  typedef struct packed {
    logic [1:0] fa, fb;
    logic [3:0] stl;
    logic [2:0] fls;
  } out_t;

  typedef struct packed {
    inp_t in;
    out_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  // reference model state: consecutive not-ready cycles of the current wait
  // (0 = not waiting), sticky fault, counter values
  int   m_pend = 0;
  bit   m_fault = 1'b0;
  int   m_sc = 0;
  int   m_fc = 0;
  out_t s_out;

  hazard_if #(.CW(CW)) hif ();

  hazard_ctrl #(.TIMEOUT(TIMEOUT), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hif)
  );

  always #5 clk = ~clk;

  function automatic inp_t mk_in(int r, int rs1d, int rs2d, int rs1e, int rs2e,
                                 int rde, int rdm, int rdw, int regwm, int regww,
                                 int lde, int pcsrc, int memreq, int memrdy);
    inp_t o;
    o.rst_n  = 1'(r);
    o.rs1d   = 5'(rs1d);
    o.rs2d   = 5'(rs2d);
    o.rs1e   = 5'(rs1e);
    o.rs2e   = 5'(rs2e);
    o.rde    = 5'(rde);
    o.rdm    = 5'(rdm);
    o.rdw    = 5'(rdw);
    o.regwm  = 1'(regwm);
    o.regww  = 1'(regww);
    o.lde    = 1'(lde);
    o.pcsrc  = 1'(pcsrc);
    o.memreq = 1'(memreq);
    o.memrdy = 1'(memrdy);
    return o;
  endfunction

  function automatic out_t mk_out(int fa, int fb, int stl, int fls);
    out_t o;
    o.fa  = 2'(fa);
    o.fb  = 2'(fb);
    o.stl = 4'(stl);
    o.fls = 3'(fls);
    return o;
  endfunction

  function automatic logic [1:0] ref_fwd(inp_t in, logic [4:0] rs);
    if (in.regwm && in.rdm != 0 && in.rdm == rs) return 2'b10;
    if (in.regww && in.rdw != 0 && in.rdw == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic out_t ref_out(inp_t in);
    out_t o = '0;
    bit   lw, mw;
    if (!in.rst_n) return o;
    o.fa = ref_fwd(in, in.rs1e);
    o.fb = ref_fwd(in, in.rs2e);
    lw = in.lde && in.rde != 0 && (in.rde == in.rs1d || in.rde == in.rs2d);
    mw = in.memreq && !in.memrdy;
    if (m_fault || mw) begin
      o.stl = 4'b1111;
      o.fls = 3'b001;
    end else if (in.pcsrc) begin
      o.fls = 3'b110;
    end else if (lw) begin
      o.stl = 4'b1100;
      o.fls = 3'b010;
    end
    return o;
  endfunction

  task automatic ref_edge(inp_t in, out_t o);
    if (!in.rst_n) begin
      m_pend = 0; m_fault = 1'b0; m_sc = 0; m_fc = 0;
    end else begin
      if (o.stl != 0) m_sc = (m_sc < SMAX) ? m_sc + 1 : SMAX;
      if (o.fls[2])   m_fc = (m_fc < SMAX) ? m_fc + 1 : SMAX;
      if (!m_fault) begin
        if (m_pend == 0) begin
          if (in.memreq && !in.memrdy) m_pend = 1;
        end else if (in.memrdy) begin
          m_pend = 0;
        end else begin
          m_pend = m_pend + 1;
          if (m_pend == TIMEOUT) begin
            m_fault = 1'b1;
            m_pend  = 0;
          end
        end
      end
    end
  endtask

  task automatic chk(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // drive one cycle, check every output against the model, advance one edge
  task automatic apply(inp_t in);
    out_t e;
    rst              = in.rst_n;
    hif.Rs1D         = in.rs1d;
    hif.Rs2D         = in.rs2d;
    hif.Rs1E         = in.rs1e;
    hif.Rs2E         = in.rs2e;
    hif.RdE          = in.rde;
    hif.RdM          = in.rdm;
    hif.RdW          = in.rdw;
    hif.RegWriteM    = in.regwm;
    hif.RegWriteW    = in.regww;
    hif.ResultSrcE0  = in.lde;
    hif.PCSrcE       = in.pcsrc;
    hif.MemReqM      = in.memreq;
    hif.MemReadyM    = in.memrdy;
    #3;
    e = ref_out(in);
    s_out.fa  = hif.ForwardAE;
    s_out.fb  = hif.ForwardBE;
    s_out.stl = {hif.StallF, hif.StallD, hif.StallE, hif.StallM};
    s_out.fls = {hif.FlushD, hif.FlushE, hif.FlushW};
    chk("fwdA",     int'(s_out.fa),  int'(e.fa));
    chk("fwdB",     int'(s_out.fb),  int'(e.fb));
    chk("stalls",   int'(s_out.stl), int'(e.stl));
    chk("flushes",  int'(s_out.fls), int'(e.fls));
    chk("memfault", int'(hif.MemFault), int'(m_fault));
    chk("stallcnt", int'(hif.StallCount), m_sc);
    chk("flushcnt", int'(hif.FlushCount), m_fc);
    @(posedge clk);
    ref_edge(in, e);
    #1;
  endtask

  inp_t idle, rst_in, lu, br_lu, mw_pc, mr_pc, mw, inr;
  vec_t tbl[12];

  initial begin
    idle   = mk_in(1, 0,0,0,0,0,0,0, 0,0,0,0,0,1);
    rst_in = mk_in(0, 0,0,0,0,0,0,0, 0,0,0,0,0,1);
    lu     = mk_in(1, 0,7,0,0,7,0,0, 0,0,1,0,0,1);
    br_lu  = mk_in(1, 0,7,0,0,7,0,0, 0,0,1,1,0,1);
    mw_pc  = mk_in(1, 0,0,0,0,0,0,0, 0,0,0,1,1,0);
    mr_pc  = mk_in(1, 0,0,0,0,0,0,0, 0,0,0,1,1,1);
    mw     = mk_in(1, 0,0,0,0,0,0,0, 0,0,0,0,1,0);

    //                       r rs1d rs2d rs1e rs2e rde rdm rdw wm ww ld pc rq rdy
    tbl[0]  = '{mk_in(1, 0, 0, 5, 0, 0, 5, 5, 1, 1, 0, 0, 0, 1), mk_out(2, 0, 4'b0000, 3'b000)};
    tbl[1]  = '{mk_in(1, 0, 0, 5, 0, 0, 0, 5, 1, 1, 0, 0, 0, 1), mk_out(1, 0, 4'b0000, 3'b000)};
    tbl[2]  = '{mk_in(1, 0, 0, 0, 5, 0, 5, 5, 0, 0, 0, 0, 0, 1), mk_out(0, 0, 4'b0000, 3'b000)};
    tbl[3]  = '{mk_in(1, 0, 0, 6, 5, 0, 6, 5, 1, 1, 0, 0, 0, 1), mk_out(2, 1, 4'b0000, 3'b000)};
    tbl[4]  = '{mk_in(1, 0, 7, 0, 0, 7, 0, 0, 0, 0, 1, 0, 0, 1), mk_out(0, 0, 4'b1100, 3'b010)};
    tbl[5]  = '{mk_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1), mk_out(0, 0, 4'b0000, 3'b000)};
    tbl[6]  = '{mk_in(1, 7, 0, 0, 0, 7, 0, 0, 0, 0, 1, 1, 0, 1), mk_out(0, 0, 4'b0000, 3'b110)};
    tbl[7]  = '{mk_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0), mk_out(0, 0, 4'b1111, 3'b001)};
    tbl[8]  = '{mk_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1), mk_out(0, 0, 4'b0000, 3'b110)};
    tbl[9]  = '{mk_in(1, 7, 0, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0, 1), mk_out(0, 0, 4'b0000, 3'b000)};
    tbl[10] = '{mk_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), mk_out(0, 0, 4'b0000, 3'b000)};
    tbl[11] = '{mk_in(0, 7, 0, 5, 5, 7, 5, 5, 1, 1, 1, 1, 1, 0), mk_out(0, 0, 4'b0000, 3'b000)};

    // bring the DUT out of its power-up state before any comparison
    rst = 1'b0;
    hif.Rs1D = '0; hif.Rs2D = '0; hif.Rs1E = '0; hif.Rs2E = '0; hif.RdE = '0;
    hif.RdM = '0; hif.RdW = '0; hif.RegWriteM = 1'b0; hif.RegWriteW = 1'b0;
    hif.ResultSrcE0 = 1'b0; hif.PCSrcE = 1'b0; hif.MemReqM = 1'b0; hif.MemReadyM = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;

    // reset state
    apply(rst_in);
    chk("rst_memfault", int'(hif.MemFault), 0);
    chk("rst_stallcnt", int'(hif.StallCount), 0);
    chk("rst_flushcnt", int'(hif.FlushCount), 0);

    // table vectors
    for (int i = 0; i < 12; i++) begin
      apply(tbl[i].in);
      chk($sformatf("tbl%0d_fa", i),  int'(s_out.fa),  int'(tbl[i].exp.fa));
      chk($sformatf("tbl%0d_fb", i),  int'(s_out.fb),  int'(tbl[i].exp.fb));
      chk($sformatf("tbl%0d_stl", i), int'(s_out.stl), int'(tbl[i].exp.stl));
      chk($sformatf("tbl%0d_fls", i), int'(s_out.fls), int'(tbl[i].exp.fls));
    end

    // load-use: one stall cycle, then the bubble clears it
    apply(rst_in);
    apply(lu);
    chk("lu_stall", int'(s_out.stl), 4'b1100);
    chk("lu_flush", int'(s_out.fls), 3'b010);
    apply(idle);
    chk("lu_bubble", int'(s_out.stl), 0);
    chk("lu_stallcnt", int'(hif.StallCount), 1);

    // branch beats load-use
    apply(rst_in);
    apply(br_lu);
    chk("br_flush", int'(s_out.fls), 3'b110);
    chk("br_stall", int'(s_out.stl), 0);
    apply(idle);
    chk("br_flushcnt", int'(hif.FlushCount), 1);
    chk("br_stallcnt", int'(hif.StallCount), 0);

    // memory wait of 3 cycles with a pending redirect; ready on the 4th
    // cycle coincides with the timeout check and must win
    apply(rst_in);
    for (int i = 0; i < 3; i++) begin
      apply(mw_pc);
      chk("mw_stall", int'(s_out.stl), 4'b1111);
      chk("mw_flush", int'(s_out.fls), 3'b001);
    end
    apply(mr_pc);
    chk("mw_end_stall", int'(s_out.stl), 0);
    chk("mw_end_flush", int'(s_out.fls), 3'b110);
    apply(idle);
    chk("mw_nofault", int'(hif.MemFault), 0);
    chk("mw_stallcnt", int'(hif.StallCount), 3);
    chk("mw_flushcnt", int'(hif.FlushCount), 1);

    // timeout: fault after TIMEOUT not-ready cycles, stalls hold, reset clears
    apply(rst_in);
    for (int i = 0; i < TIMEOUT; i++) begin
      chk("to_prefault", int'(hif.MemFault), 0);
      apply(mw);
    end
    chk("to_fault", int'(hif.MemFault), 1);
    for (int i = 0; i < 5; i++) begin
      apply(idle);
      chk("to_hold", int'(s_out.stl), 4'b1111);
    end
    chk("to_stallcnt", int'(hif.StallCount), 9);
    apply(rst_in);
    chk("to_rst_fault", int'(hif.MemFault), 0);
    chk("to_rst_scnt", int'(hif.StallCount), 0);
    apply(idle);
    chk("to_rst_run", int'(s_out.stl), 0);

    // reset in the middle of a wait
    apply(rst_in);
    apply(mw);
    apply(mw);
    inr = mw;
    inr.rst_n = 1'b0;
    apply(inr);
    chk("mid_rst_stl", int'(s_out.stl), 0);
    chk("mid_rst_scnt", int'(hif.StallCount), 0);
    apply(idle);
    chk("mid_rst_run", int'(s_out.stl), 0);

    // saturation
    apply(rst_in);
    for (int i = 0; i < 20; i++) apply(lu);
    chk("sat_15", int'(hif.StallCount), SMAX);
    apply(lu);
    chk("sat_hold", int'(hif.StallCount), SMAX);

    // random stimulus against the model
    apply(rst_in);
    for (int n = 0; n < 2500; n++) begin
      inr.rst_n  = ($urandom_range(0, 29) != 0);
      inr.rs1d   = 5'($urandom_range(0, 3));
      inr.rs2d   = 5'($urandom_range(0, 3));
      inr.rs1e   = 5'($urandom_range(0, 3));
      inr.rs2e   = 5'($urandom_range(0, 3));
      inr.rde    = 5'($urandom_range(0, 3));
      inr.rdm    = 5'($urandom_range(0, 3));
      inr.rdw    = 5'($urandom_range(0, 3));
      inr.regwm  = 1'($urandom_range(0, 1));
      inr.regww  = 1'($urandom_range(0, 1));
      inr.lde    = ($urandom_range(0, 2) == 0);
      inr.pcsrc  = ($urandom_range(0, 3) == 0);
      inr.memreq = ($urandom_range(0, 3) == 0);
      inr.memrdy = ($urandom_range(0, 9) < 6);
      apply(inr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the RV32I 5-stage core: it sequences the F/D/E/M/W pipeline registers around data hazards, control hazards and slow data-memory accesses. It produces the E-stage forwarding selects, load-use stalls, taken-branch/jump flushes and a whole-pipeline freeze while the data memory is not ready. It also runs a memory-wait timeout FSM and keeps saturating stall/flush performance counters. It sits beside the Control_Unit and drives the enable/clear pins of the four pipeline registers.

## Interface
Parameters:
- TIMEOUT, 16, max consecutive memory-wait cycles before fault (≥2)
- CW, 16, width of performance counters

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  synchronous, active-low reset
- Rs1D, Rs2D  in  5  source regs of instruction in D
- Rs1E, Rs2E, RdE  in  5  source/dest regs in E
- RdM, RdW  in  5  dest regs in M and W
- RegWriteM, RegWriteW  in  1  write enables in M and W
- ResultSrcE0  in  1  bit 0 of ResultSrc in E (1 = load)
- PCSrcE  in  1  branch taken or jump resolved in E
- MemReqM  in  1  M-stage instruction accesses data memory
- MemReadyM  in  1  data memory completes access this cycle
- ForwardAE, ForwardBE  out  2  00 = reg file, 01 = W result, 10 = M ALU result
- StallF, StallD, StallE, StallM  out  1  hold pipeline register
- FlushD, FlushE, FlushW  out  1  clear pipeline register to bubble
- MemFault  out  1  sticky memory-timeout fault
- StallCount, FlushCount  out  CW  saturating performance counters

## Operation
- Forwarding (combinational):
  - ForwardAE = 10 if RegWriteM & RdM≠0 & RdM==Rs1E; else 01 if RegWriteW & RdW≠0 & RdW==Rs1E; else 00.
  - ForwardBE is the same using Rs2E.
  - M has priority over W.
- lwStall = ResultSrcE0 & RdE≠0 & (RdE==Rs1D | RdE==Rs2D).
- memWait = MemReqM & ~MemReadyM.
- FSM states: RUN, WAIT, FAULT.
- RUN:
  - Outputs, in priority order:
    - If memWait: StallF=StallD=StallE=StallM=1, FlushW=1; all other stalls/flushes 0. Flushes and lwStall are deferred.
    - Else if PCSrcE: FlushD=FlushE=1, StallF=StallD=0. The flush overrides a simultaneous lwStall.
    - Else if lwStall: StallF=StallD=1, FlushE=1.
    - Else: all stall and flush outputs 0.
  - Transition: memWait → WAIT with wait_cnt=1; otherwise stay in RUN.
- WAIT:
  - Outputs: same as RUN, with the same priority rules.
  - If MemReadyM → RUN, wait_cnt=0.
  - Else if wait_cnt==TIMEOUT-1 → FAULT.
  - Else wait_cnt+1.
- FAULT:
  - StallF/D/E/M=1, FlushW=1, MemFault=1.
  - Left only by reset.
- Counters:
  - StallCount +1 on every clock edge where any Stall* output is 1.
  - FlushCount +1 on every edge where PCSrcE causes FlushD.
  - Both saturate at 2^CW-1 and never wrap.
- Reset (rst=0 at an edge): state=RUN, wait_cnt=0, MemFault=0, counters=0.
- While rst=0, all Stall*/Flush* outputs are forced to 0 and ForwardAE/BE to 00.

## Timing
- Forward, stall and flush outputs are Mealy and combinational from the current inputs and state. They are valid in the same cycle, with zero-cycle latency.
- A load-use hazard produces exactly a 1-cycle stall: the bubble in E clears lwStall the next cycle.
- Memory freeze lasts exactly as many cycles as MemReadyM is low. Stalls drop in the cycle MemReadyM=1.
- Fault timing: MemFault rises on the edge after the TIMEOUT-th consecutive not-ready cycle. There is no TIMEOUT-th+1 stall cycle in RUN/WAIT; FAULT holds the stalls.
- MemReadyM rising in the same cycle as the timeout check → RUN. Ready wins.
- Reset asserted mid-WAIT or in FAULT: RUN is entered at that edge and no counter increments at that edge.
- Counter increments are registered and visible one cycle after the qualifying cycle.

## Test plan
- Forwarding: RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5 → ForwardAE=10. With RdM=0 → 01. With Rs2E=5, RegWriteM=0, RegWriteW=0 → ForwardBE=00.
- Load-use: ResultSrcE0=1, RdE=7, Rs2D=7 → StallF=StallD=FlushE=1 for 1 cycle. Next cycle the bubble is in E → all 0. StallCount=1.
- Branch vs load-use: PCSrcE=1 together with lwStall → FlushD=FlushE=1, StallF=StallD=0, FlushCount=1.
- Memory wait: MemReqM=1, MemReadyM low for 3 cycles, then high → StallF/D/E/M=FlushW=1 for 3 cycles, 0 on the 4th. A PCSrcE=1 held during the wait does not flush until the wait ends. StallCount=3.
- Timeout: TIMEOUT=4, MemReadyM held low → MemFault=1 after 4 wait cycles, stalls stay high indefinitely. Then rst=0 for 1 edge → MemFault=0, counters=0, state RUN.
- Saturation: CW=4, 20 consecutive stall cycles → StallCount=15 and it holds there.
